// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative 32-bit signed/unsigned multiply/divide unit with HI/LO registers
module muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    state_t      state;
    logic [5:0]  cnt;
    logic        is_div;
    logic        neg_a;
    logic        neg_b;
    logic        div_zero;
    logic [31:0] orig_a;
    logic [31:0] opb;
    // Working pair: {acc_hi, acc_lo} is the 64-bit product accumulator for
    // multiply, and {remainder, quotient} for divide.
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;

    // Operand conditioning at start: magnitude for signed ops, as-is otherwise
    logic        signed_in;
    logic        a_neg_in;
    logic        b_neg_in;
    logic [31:0] abs_a_in;
    logic [31:0] abs_b_in;

    // Per-iteration datapath and final sign correction
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [63:0] prod;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign busy = (state != IDLE);

    // Sign detection and absolute value of the incoming operands
    always_comb begin
        signed_in = (op == OP_MULT) || (op == OP_DIV);
        a_neg_in  = signed_in && src_a[31];
        b_neg_in  = signed_in && src_b[31];
        abs_a_in  = a_neg_in ? (32'd0 - src_a) : src_a;
        abs_b_in  = b_neg_in ? (32'd0 - src_b) : src_b;
    end

    // One shift-add (multiply) or restoring shift-subtract (divide) step
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opb : 32'd0)};
        div_shift = {acc_hi, acc_lo[31]};
        div_diff  = div_shift - {1'b0, opb};
        div_ge    = ~div_diff[32];
    end

    // Sign correction applied when leaving FIX
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = (neg_a ^ neg_b) ? (64'd0 - prod) : prod;
        quo_fix  = (neg_a ^ neg_b) ? (32'd0 - acc_lo) : acc_lo;
        rem_fix  = neg_a ? (32'd0 - acc_hi) : acc_hi;
    end

    // Control FSM, iteration datapath and HI/LO architectural registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 6'd0;
            done     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            is_div   <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            orig_a   <= 32'd0;
            opb      <= 32'd0;
            acc_hi   <= 32'd0;
            acc_lo   <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        is_div   <= (op == OP_DIV) || (op == OP_DIVU);
                        neg_a    <= a_neg_in;
                        neg_b    <= b_neg_in;
                        div_zero <= ((op == OP_DIV) || (op == OP_DIVU)) && (src_b == 32'd0);
                        orig_a   <= src_a;
                        opb      <= abs_b_in;
                        acc_hi   <= 32'd0;
                        acc_lo   <= abs_a_in;
                        cnt      <= 6'd0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc_hi <= div_ge ? div_diff[31:0] : div_shift[31:0];
                        acc_lo <= {acc_lo[30:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[32:1];
                        acc_lo <= {mul_sum[0], acc_lo[31:1]};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) state <= FIX;
                end
                FIX: begin
                    if (!is_div) begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end else if (div_zero) begin
                        hi <= orig_a;
                        lo <= 32'hFFFF_FFFF;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 start  input  1  request a new operation; sampled only while busy=0.
REQ-003 op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-004 src_a  input  32  multiplicand or dividend, taken from the ALU operand-A mux output.
REQ-005 src_b  input  32  multiplier or divisor, taken from the ALU operand-B mux output.
REQ-006 hi_we  input  1  MTHI write enable.
REQ-007 lo_we  input  1  MTLO write enable.
REQ-008 wdata  input  32  data for MTHI/MTLO.
REQ-009 busy  output  1  operation in progress; the pipeline stalls on busy=1.
REQ-010 done  output  1  one-cycle pulse; hi/lo hold a fresh result.
REQ-011 hi  output  32  HI register: product[63:32] or remainder.
REQ-012 lo  output  32  LO register: product[31:0] or quotient.

Function
REQ-013 The FSM SHALL use states IDLE, CALC and FIX; busy SHALL equal (state != IDLE).
REQ-014 In IDLE with start=1 at edge E0, the block SHALL latch op, sign flags, |src_a| and |src_b|, clear a 6-bit iteration counter, and enter CALC.
- Absolute value applies to signed ops only.
- Unsigned ops take the operands as-is.
REQ-015 In CALC, each cycle SHALL process exactly one bit.
- Multiply: shift-add into a 64-bit accumulator.
- Divide: restoring shift-subtract into a 32-bit remainder and 32-bit quotient.
- Edges E1..E32 are the 32 iterations; after E32 the FSM is in FIX.
REQ-016 In FIX (edge E33), the block SHALL apply sign correction and write hi/lo, assert done for the following cycle only, and return to IDLE.
- Total: busy high for 33 cycles; done high in the cycle after E33 with busy=0.
REQ-017 MULT sign rule: the 64-bit product SHALL be two's-complement negated when the operand signs differ.
REQ-018 DIV sign rule: the quotient SHALL be negated when the signs differ; the remainder SHALL take the sign of the dividend.
REQ-019 Divide by zero (src_b=0, DIV or DIVU) SHALL still take 33 cycles and produce lo=0xFFFFFFFF, hi=src_a (original, unconverted value).
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL produce lo=0x80000000, hi=0x00000000 with no exception.
REQ-021 start while busy=1 SHALL be ignored; the current operation SHALL continue unchanged.
REQ-022 hi_we/lo_we in IDLE SHALL write wdata to hi/lo at that edge.
- Both may be asserted together.
- If start is also asserted at that edge, the write SHALL take effect and the operation SHALL later overwrite both hi and lo.
REQ-023 hi_we/lo_we while busy=1 SHALL be ignored.
REQ-024 hi and lo SHALL change only on: reset, an MTHI/MTLO write in IDLE, or exit from FIX.
REQ-025 src_a, src_b and op changes after E0 SHALL NOT affect the in-flight operation.

Reset
REQ-026 When rst=1 at a rising edge, the block SHALL set state=IDLE, busy=0, done=0, hi=0, lo=0 and counter=0; rst SHALL take priority over start and over write enables.
REQ-027 Reset mid-operation SHALL abandon the operation with no hi/lo update and no done pulse; start SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-028 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles; done in cycle 34 after start.
REQ-029 MULT 0xFFFFFFFD x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-030 DIV 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-031 DIVU 0x00000064 / 0 -> lo=0xFFFFFFFF, hi=0x00000064 after 33 busy cycles.
REQ-032 During a busy op, pulse start (op=11, new operands) and hi_we (wdata=0x12345678) -> both ignored; the original result is written; a single done pulse.
REQ-033 Assert rst at CALC iteration 10 -> next cycle busy=0, hi=lo=0, done never pulses; a new MULTU 3 x 5 then gives lo=0x0000000F, hi=0.
